// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: execute-side request/response bundle for the M-extension sequencer.
interface muldiv_ctrl_if #(parameter int XLEN = 32);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            kill_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    modport master (output start_i, funct3_i, rs1_i, rs2_i, kill_i, input busy_o, done_o, result_o);
    modport slave (input start_i, funct3_i, rs1_i, rs2_i, kill_i, output busy_o, done_o, result_o);
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: RV32M sequencer running radix-2 shift-add multiply / restoring divide on operand magnitudes,
// with single-cycle completion of zero, divide-by-zero and signed-overflow cases.
module muldiv_ctrl #(
    parameter int XLEN = 32,
    parameter int ITER = XLEN
) (
    input  logic         clk_i,
    input  logic         reset_i,
    muldiv_ctrl_if.slave io
);
    typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;
    localparam int CW = $clog2(ITER);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opd_q, opd_d, result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              accept, is_div, sgn_a, sgn_b, b_zero, ovf, special, div_ge;
    logic [XLEN-1:0]   mag_a, mag_b, spec_res, div_sub, quo, rem;
    logic [XLEN:0]     mul_sum, div_shift;
    logic [2*XLEN-1:0] prod;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opd_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opd_q    <= opd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end
    always_comb begin
        state_d = io.kill_i ? IDLE :
                  state_q == IDLE ? (accept ? (special ? DONE : RUN) : IDLE) :
                  state_q == RUN  ? (cnt_q == CW'(ITER - 1) ? SIGN : RUN) :
                  state_q == SIGN ? DONE : IDLE;
    end
    always_comb begin
        accept   = state_q == IDLE && io.start_i && !io.kill_i;
        is_div   = io.funct3_i[2];
        sgn_a    = !(io.funct3_i inside {3'b011, 3'b101, 3'b111});
        sgn_b    = io.funct3_i inside {3'b000, 3'b001, 3'b100, 3'b110};
        mag_a    = (sgn_a && io.rs1_i[XLEN-1]) ? -io.rs1_i : io.rs1_i;
        mag_b    = (sgn_b && io.rs2_i[XLEN-1]) ? -io.rs2_i : io.rs2_i;
        b_zero   = io.rs2_i == '0;
        ovf      = !io.funct3_i[0] && io.rs1_i == MIN && io.rs2_i == '1;
        special  = is_div ? (b_zero || ovf) : (io.rs1_i == '0 || b_zero);
        spec_res = !is_div ? '0 : b_zero ? (io.funct3_i[1] ? io.rs1_i : '1) : (io.funct3_i[1] ? '0 : MIN);
        // acc holds {product hi, multiplier lo} for multiply and {remainder, dividend/quotient} for divide
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q & {XLEN{acc_q[0]}}};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opd_q};
        div_sub   = div_shift[XLEN-1:0] - opd_q;
        prod      = neg_q ? -acc_q : acc_q;
        quo       = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem       = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        op_d      = op_q;
        neg_d     = neg_q;
        opd_d     = opd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        if (accept) begin
            op_d     = io.funct3_i;
            neg_d    = (sgn_b && io.funct3_i != 3'b110) ? io.rs1_i[XLEN-1] ^ io.rs2_i[XLEN-1] : sgn_a & io.rs1_i[XLEN-1];
            opd_d    = is_div ? mag_b : mag_a;
            acc_d    = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
            cnt_d    = '0;
            result_d = special ? spec_res : result_q;
        end else if (state_q == RUN && !io.kill_i) begin
            acc_d = op_q[2] ? (div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0})
                            : {mul_sum, acc_q[XLEN-1:1]};
            cnt_d = cnt_q + 1'b1;
        end else if (state_q == SIGN && !io.kill_i) begin
            result_d = !op_q[2] ? (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                                : (op_q[1] ? rem : quo);
        end
    end
    always_comb begin
        io.busy_o   = state_q != IDLE;
        io.done_o   = state_q == DONE;
        io.result_o = result_q;
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench; driver pushes model results and due cycles, a negedge monitor checks each done pulse.
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] model_res = '0;
    typedef struct {logic [31:0] res; int due;} exp_t;
    typedef struct {logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] r;} vec_t;
    exp_t sb[$];
    vec_t dir [12] = '{
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000},
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
        '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
        '{3'd4, 32'h0000002A, 32'h00000000, 32'hFFFFFFFF},
        '{3'd7, 32'h00000005, 32'h00000000, 32'h00000005},
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
        '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},
        '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},
        '{3'd5, 32'd100, 32'd7, 32'd14},
        '{3'd7, 32'd100, 32'd7, 32'd2},
        '{3'd0, 32'd3, 32'd0, 32'd0}
    };

    muldiv_ctrl_if bus();
    muldiv_ctrl dut (.clk_i(clk), .reset_i(rst), .io(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_res(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint sx, sy, ux, uy, p;
        sx = longint'(signed'(a));
        sy = longint'(signed'(b));
        ux = longint'({32'b0, a});
        uy = longint'({32'b0, b});
        case (f)
            3'd0, 3'd1: p = sx * sy;
            3'd2:       p = sx * uy;
            3'd3:       p = ux * uy;
            3'd4:       p = (b == 0) ? -1 : sx / sy;
            3'd5:       p = (b == 0) ? -1 : ux / uy;
            3'd6:       p = (b == 0) ? sx : sx % sy;
            default:    p = (b == 0) ? ux : ux % uy;
        endcase
        return (f == 3'd1 || f == 3'd2 || f == 3'd3) ? p[63:32] : p[31:0];
    endfunction

    function automatic int lat(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        if (f[2]) return (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 0 : 33;
        return (a == 0 || b == 0) ? 0 : 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'h7FFFFFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // called at a negedge with the DUT idle; returns #1 after the accept edge
    task automatic send(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [31:0] r);
        bus.start_i  = 1'b1;
        bus.funct3_i = f;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        sb.push_back('{res: r, due: cyc + lat(f, a, b)});
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done_o) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with result %h expected no done", bus.result_o);
            end else begin
                e = sb.pop_front();
                check("result", bus.result_o, e.res);
                check("latency", cyc, e.due);
                model_res = e.res;
            end
        end
    end

    initial begin
        logic [2:0] f;
        logic [31:0] a, b;
        int bad;
        bus.start_i  = 1'b0;
        bus.kill_i   = 1'b0;
        bus.funct3_i = '0;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy_o, 0);
        check("reset_done", bus.done_o, 0);
        check("reset_result", bus.result_o, 0);
        rst = 1'b0;
        @(negedge clk);
        send(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
        bad = 0;
        repeat (34) begin
            @(negedge clk);
            if (bus.busy_o !== 1'b1) bad++;
        end
        check("busy_window_low_cycles", bad, 0);
        @(negedge clk);
        check("busy_after_done", bus.busy_o, 0);
        drain();
        foreach (dir[i]) begin
            send(dir[i].f, dir[i].a, dir[i].b, dir[i].r);
            drain();
        end
        repeat (60) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            send(f, a, b, ref_res(f, a, b));
            drain();
        end
        send(3'd0, 32'h00012345, 32'h00006789, ref_res(3'd0, 32'h00012345, 32'h00006789));
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.kill_i = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        bus.kill_i = 1'b0;
        check("kill_busy", bus.busy_o, 0);
        check("kill_result", bus.result_o, model_res);
        repeat (40) @(negedge clk);
        check("kill_result_held", bus.result_o, model_res);
        bus.start_i  = 1'b1;
        bus.kill_i   = 1'b1;
        bus.funct3_i = 3'd0;
        bus.rs1_i    = 32'd5;
        bus.rs2_i    = 32'd6;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        check("kill_over_start_busy", bus.busy_o, 0);
        repeat (40) @(negedge clk);
        send(3'd5, 32'd1000, 32'd3, 32'd333);
        repeat (5) @(negedge clk);
        bus.start_i  = 1'b1;
        bus.funct3_i = 3'd0;
        bus.rs1_i    = 32'd2;
        bus.rs2_i    = 32'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        check("ignored_start_result", bus.result_o, 32'd333);
        send(3'd0, 32'h00001234, 32'h00005678, ref_res(3'd0, 32'h00001234, 32'h00005678));
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_busy", bus.busy_o, 0);
        check("async_reset_result", bus.result_o, 0);
        check("async_reset_done", bus.done_o, 0);
        sb.delete();
        model_res = '0;
        @(negedge clk);
        rst = 1'b0;
        send(3'd0, 32'd3, 32'd4, 32'd12);
        drain();
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
